// File: rtl/led_matrix_scan_driver.sv
// Multiplexed RGB LED matrix scan driver: per-line blanking, shadowed pixel data,
// BITS-bit PWM compare and registered, polarity-selectable panel outputs.
module led_matrix_scan_driver #(
    parameter int NCOL       = 8,
    parameter int NPIX       = 16,
    parameter int BITS       = 8,
    parameter int REP_LOG    = 7,
    parameter int BLANK      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NPIX*3*BITS-1:0]     values,
    output logic [$clog2(NCOL)-1:0]    line,
    output logic                       line_load,
    output logic                       vsync,
    output logic [NCOL-1:0]            col,
    output logic [NPIX-1:0]            red,
    output logic [NPIX-1:0]            green,
    output logic [NPIX-1:0]            blue
);

    localparam int CW = BITS + REP_LOG;
    localparam int LW = $clog2(NCOL);
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_LOAD, S_SCAN} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [BW-1:0]          bcnt, bcnt_nx;
    logic [LW-1:0]          line_nx;
    logic [NPIX*3*BITS-1:0] shadow;
    logic [BITS-1:0]        pwm;
    logic [NCOL-1:0]        col_q, col_nx;
    logic [NPIX-1:0]        red_q, red_nx, green_q, green_nx, blue_q, blue_nx;

    assign pwm = cnt[BITS-1:0];

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        bcnt_nx   = bcnt;
        line_nx   = line;
        line_load = 1'b0;
        vsync     = 1'b0;
        col_nx    = '0;
        red_nx    = '0;
        green_nx  = '0;
        blue_nx   = '0;
        case (state)
            S_IDLE: begin
                bcnt_nx = '0;
                if (en) state_nx = S_BLANK;
            end
            S_BLANK: begin
                if (bcnt == BW'(BLANK - 1)) begin
                    state_nx = S_LOAD;
                end else begin
                    bcnt_nx = bcnt + 1'b1;
                end
            end
            S_LOAD: begin
                line_load = 1'b1;
                cnt_nx    = '0;
                state_nx  = S_SCAN;
            end
            S_SCAN: begin
                cnt_nx = cnt + 1'b1;
                col_nx = NCOL'(1) << line;
                // Pixel p packs {R,G,B}, R in the most significant BITS slice.
                for (int unsigned p = 0; p < NPIX; p++) begin
                    red_nx[p]   = shadow[p*3*BITS + 2*BITS +: BITS] > pwm;
                    green_nx[p] = shadow[p*3*BITS + BITS   +: BITS] > pwm;
                    blue_nx[p]  = shadow[p*3*BITS          +: BITS] > pwm;
                end
                if (cnt == '1) begin
                    bcnt_nx = '0;
                    if (line == LW'(NCOL - 1)) begin
                        vsync    = 1'b1;
                        line_nx  = '0;
                        state_nx = en ? S_BLANK : S_IDLE;
                    end else begin
                        line_nx  = line + 1'b1;
                        state_nx = S_BLANK;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bcnt    <= '0;
            line    <= '0;
            shadow  <= '0;
            col_q   <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bcnt    <= bcnt_nx;
            line    <= line_nx;
            col_q   <= col_nx;
            red_q   <= red_nx;
            green_q <= green_nx;
            blue_q  <= blue_nx;
            if (line_load) shadow <= values;
        end
    end

    assign col   = (ACTIVE_LOW != 0) ? ~col_q   : col_q;
    assign red   = (ACTIVE_LOW != 0) ? ~red_q   : red_q;
    assign green = (ACTIVE_LOW != 0) ? ~green_q : green_q;
    assign blue  = (ACTIVE_LOW != 0) ? ~blue_q  : blue_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Randomised bench for led_matrix_scan_driver: active-high and active-low instances
// checked every cycle against a line-position reference model.
module tb_led_matrix_scan_driver;

    localparam int NCOL     = 2;
    localparam int NPIX     = 2;
    localparam int BITS     = 2;
    localparam int REP_LOG  = 1;
    localparam int BLANK    = 2;
    localparam int LINE_LEN = BLANK + 1 + (1 << (BITS + REP_LOG));
    localparam int VW       = NPIX * 3 * BITS;

    logic            clk = 1'b0;
    logic            rst, en;
    logic [VW-1:0]   values;

    logic [0:0]      line_h, line_l;
    logic            load_h, load_l, vsync_h, vsync_l;
    logic [NCOL-1:0] col_h, col_l;
    logic [NPIX-1:0] red_h, green_h, blue_h, red_l, green_l, blue_l;

    led_matrix_scan_driver #(.NCOL(NCOL), .NPIX(NPIX), .BITS(BITS), .REP_LOG(REP_LOG),
                             .BLANK(BLANK), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .en(en), .values(values), .line(line_h),
        .line_load(load_h), .vsync(vsync_h), .col(col_h),
        .red(red_h), .green(green_h), .blue(blue_h));

    led_matrix_scan_driver #(.NCOL(NCOL), .NPIX(NPIX), .BITS(BITS), .REP_LOG(REP_LOG),
                             .BLANK(BLANK), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst(rst), .en(en), .values(values), .line(line_l),
        .line_load(load_l), .vsync(vsync_l), .col(col_l),
        .red(red_l), .green(green_l), .blue(blue_l));

    always #5 clk = ~clk;

    // Reference model: position within the current line, plus an idle flag.
    bit              m_idle;
    int              m_line, m_pos;
    int              sh_r[NPIX], sh_g[NPIX], sh_b[NPIX];
    logic [NCOL-1:0] exp_col, exp_col_n;
    logic [NPIX-1:0] exp_r, exp_g, exp_b, exp_r_n, exp_g_n, exp_b_n;
    int              n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chan(input logic [VW-1:0] v, input int p, input int c);
        int off;
        off = p*3*BITS + (2 - c)*BITS;
        return int'(v[off +: BITS]);
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_line = 0;
        m_pos  = 0;
        exp_col = '0; exp_r = '0; exp_g = '0; exp_b = '0;
        for (int p = 0; p < NPIX; p++) begin
            sh_r[p] = 0; sh_g[p] = 0; sh_b[p] = 0;
        end
    endtask

    task automatic step(input logic n_rst, input logic n_en, input logic [VW-1:0] n_val);
        bit in_scan, in_load;
        int pwm;
        @(negedge clk);
        in_scan = !m_idle && (m_pos > BLANK);
        in_load = !m_idle && (m_pos == BLANK);
        exp_col_n = ~exp_col; exp_r_n = ~exp_r; exp_g_n = ~exp_g; exp_b_n = ~exp_b;
        check("line",      32'(line_h),  32'(m_line));
        check("line_load", 32'(load_h),  32'(in_load));
        check("vsync",     32'(vsync_h), 32'(in_scan && m_line == NCOL-1 && m_pos == LINE_LEN-1));
        check("col",       32'(col_h),   32'(exp_col));
        check("red",       32'(red_h),   32'(exp_r));
        check("green",     32'(green_h), 32'(exp_g));
        check("blue",      32'(blue_h),  32'(exp_b));
        check("line_al",   32'(line_l),  32'(m_line));
        check("col_al",    32'(col_l),   32'(exp_col_n));
        check("red_al",    32'(red_l),   32'(exp_r_n));
        check("green_al",  32'(green_l), 32'(exp_g_n));
        check("blue_al",   32'(blue_l),  32'(exp_b_n));

        rst = n_rst; en = n_en; values = n_val;
        if (n_rst) begin
            model_reset();
            return;
        end
        exp_col = '0; exp_r = '0; exp_g = '0; exp_b = '0;
        if (in_scan) begin
            pwm = (m_pos - BLANK - 1) % (1 << BITS);
            exp_col[m_line] = 1'b1;
            for (int p = 0; p < NPIX; p++) begin
                exp_r[p] = sh_r[p] > pwm;
                exp_g[p] = sh_g[p] > pwm;
                exp_b[p] = sh_b[p] > pwm;
            end
        end
        if (in_load) begin
            for (int p = 0; p < NPIX; p++) begin
                sh_r[p] = chan(n_val, p, 0);
                sh_g[p] = chan(n_val, p, 1);
                sh_b[p] = chan(n_val, p, 2);
            end
        end
        if (m_idle) begin
            if (n_en) begin m_idle = 1'b0; m_line = 0; m_pos = 0; end
        end else if (m_pos == LINE_LEN-1) begin
            m_pos = 0;
            if (m_line == NCOL-1) begin
                m_line = 0;
                if (!n_en) m_idle = 1'b1;
            end else begin
                m_line++;
            end
        end else begin
            m_pos++;
        end
    endtask

    initial begin
        logic [VW-1:0] v;
        logic          e;
        rst = 1'b1; en = 1'b0; values = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Pixel0 R=2 G=0 B=3, pixel1 off; enable straight out of reset.
        v = VW'(6'b10_00_11);
        step(1'b1, 1'b1, v);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, v);
        // Data churning every cycle, including mid-scan.
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, VW'($urandom));
        // Drop enable mid-frame, idle a while, re-enable.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, v);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, v);
        // Reset mid-scan, then resume.
        step(1'b1, 1'b1, v);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, VW'($urandom));

        e = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) e = ~e;
            if ($urandom_range(0, 2) == 0) v = VW'($urandom);
            step($urandom_range(0, 99) == 0, e, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
Parametrised multiplexed RGB LED matrix driver: scans NCOL column lines and drives NPIX RGB pixels per line with BITS-bit PWM. Over a fixed-width, free-running scanner it adds a blanking interval between lines against ghosting. Each line's pixel data is latched into a shadow register, so data changes mid-line never glitch the display. It also adds enable-gated frames, a line-load strobe to the pixel producer, and selectable output polarity. Sits between the frame/pixel source and the panel pins.

Parameters:
NCOL, 8, number of scan lines (columns); one-hot column output width
NPIX, 16, pixels driven per line (all panels combined)
BITS, 8, PWM resolution per colour channel
REP_LOG, 7, log2 of PWM periods repeated per line dwell
BLANK, 4, all-off cycles before each line (must be >= 1)
ACTIVE_LOW, 1, 1 = all column/colour outputs inverted at the pins

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  scan enable; sampled only at frame boundary
values  in  NPIX*3*BITS  pixel data for line `line`; pixel p at [(3p+3)*BITS-1 : 3p*BITS] = {R,G,B}, R most significant
line  out  clog2(NCOL)  index of line being blanked/loaded/scanned
line_load  out  1  one-cycle pulse: values sampled this cycle
vsync  out  1  one-cycle pulse on the last SCAN cycle of line NCOL-1
col  out  NCOL  one-hot column select (polarity per ACTIVE_LOW)
red  out  NPIX  red channel per pixel
green  out  NPIX  green channel per pixel
blue  out  NPIX  blue channel per pixel

Behaviour:
- Reset: state IDLE, line=0, line_load=0, vsync=0, counters 0. col/red/green/blue inactive: all 1s if ACTIVE_LOW, else all 0s.
- States:
  - IDLE: outputs inactive. If en=1, go to BLANK next cycle.
  - BLANK: BLANK cycles, outputs inactive; `line` already shows the new line so the producer has BLANK cycles to present data. Then LOAD.
  - LOAD: 1 cycle. line_load=1; shadow <= values. Then SCAN.
  - SCAN: 2^(BITS+REP_LOG) cycles with counter cnt (BITS+REP_LOG bits); pwm = cnt[BITS-1:0].
- End of SCAN:
  - Line < NCOL-1: line+1, go to BLANK.
  - Line = NCOL-1: vsync=1 on that last SCAN cycle; line wraps to 0. Next state is BLANK if en=1, else IDLE.
- Line period = BLANK + 1 + 2^(BITS+REP_LOG) cycles. Frame period = NCOL x line period.
- Colour compare, per pixel p and channel ch: on_ch[p] = (shadow_ch[p] > pwm), unsigned BITS-bit compare.
  - Value 0 never lights.
  - Value 2^BITS-1 is on for 2^BITS-1 of every 2^BITS cycles.
- col = one-hot(line) during SCAN only.
- col/red/green/blue are registered: pins reflect state/compare of the previous cycle.
  - Pins become active 1 cycle after SCAN entry and inactive 1 cycle after SCAN exit.
  - The first BLANK cycle therefore still shows the last SCAN compare; all-off is guaranteed from the second BLANK cycle. BLANK >= 2 is recommended for full blanking.
- Polarity: ACTIVE_LOW inverts only at the output stage. Internal logic is active-high.
- values changes outside LOAD have no effect on the current line.
- en deassert mid-frame: the frame completes, then IDLE. en reassert in IDLE: BLANK of line 0 next cycle.
- rst mid-line: immediate return to reset state; outputs inactive the cycle after rst is sampled.

Test Plan:
(Bench parameters: NCOL=2, NPIX=2, BITS=2, REP_LOG=1, BLANK=2, ACTIVE_LOW=0; line = 11 cycles, frame = 22.)
- Reset, en=1 -> IDLE 1 cycle; line_load at cycle 3 after reset release; vsync every 22 cycles; line sequence 0,1,0.
- Pixel0 R=2, G=0, B=3 -> per 4-cycle PWM period: red on 2 cycles, green never, blue on 3; pattern repeats twice per line.
- col is 01 during line-0 SCAN and 10 during line-1 SCAN, 1-cycle registered lag; col=00 and all colour outputs 0 from the 2nd BLANK cycle through the LOAD cycle.
- Change values mid-SCAN -> outputs unchanged until the next line_load; the new data appears on the next line.
- Drop en at line 0 -> line 1 completes, vsync fires, then IDLE with outputs 0; raise en -> BLANK of line 0 next cycle.
- Assert rst mid-SCAN -> next cycle outputs inactive, line=0; repeat with ACTIVE_LOW=1 -> all pins 1 in reset and blank.
